// File: rtl/matrix_column_scanner.sv
// rtl/matrix_column_scanner.sv - time-multiplexed 3-column LED matrix scanner with blanking
module matrix_column_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 4,
  parameter int ROW_ACTIVE_LOW = 1,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [6:0] col_2,
  input  logic [6:0] col_1,
  input  logic [6:0] col_0,
  output logic [2:0] matrix_cols,
  output logic [6:0] matrix_rows,
  output logic [1:0] current_col,
  output logic       frame_done
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [2:0]    COLS_OFF = (COL_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;
  localparam logic [6:0]    ROWS_OFF = (ROW_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  // Every slot opens dark unless blanking is disabled altogether.
  localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  state_t           state, state_n;
  logic [PW-1:0]    p, p_n;
  logic [1:0]       idx, idx_n;
  logic [2:0][6:0]  shadow, shadow_n;
  logic [6:0]       sel_col;
  logic [2:0]       cols_n;
  logic [6:0]       rows_n;
  logic [1:0]       cur_n;
  logic             fd_n;

  // State, counters, frame snapshot and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      p           <= '0;
      idx         <= '0;
      shadow      <= '0;
      matrix_cols <= COLS_OFF;
      matrix_rows <= ROWS_OFF;
      current_col <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      p           <= p_n;
      idx         <= idx_n;
      shadow      <= shadow_n;
      matrix_cols <= cols_n;
      matrix_rows <= rows_n;
      current_col <= cur_n;
      frame_done  <= fd_n;
    end
  end

  // Next-state logic; outputs are derived from the next state so they change on the same edge.
  always_comb begin
    state_n  = state;
    p_n      = p;
    idx_n    = idx;
    shadow_n = shadow;
    sel_col  = '0;
    cols_n   = COLS_OFF;
    rows_n   = ROWS_OFF;
    cur_n    = '0;
    fd_n     = 1'b0;

    case (state)
      IDLE: begin
        if (enable) begin
          state_n  = SLOT_START;
          p_n      = '0;
          idx_n    = '0;
          shadow_n = {col_2, col_1, col_0};
        end
      end
      default: begin
        if (!enable) begin
          state_n = IDLE;
          p_n     = '0;
          idx_n   = '0;
        end else if (p == P_LAST) begin
          p_n     = '0;
          state_n = SLOT_START;
          if (idx == 2'd2) begin
            // A new frame starts: the only point where the image may change.
            idx_n    = '0;
            shadow_n = {col_2, col_1, col_0};
          end else begin
            idx_n = idx + 2'd1;
          end
        end else begin
          p_n     = p + PW'(1);
          state_n = (p_n >= P_BLANK) ? DRIVE : BLANK;
        end
      end
    endcase

    case (idx_n)
      2'd0:    sel_col = shadow_n[0];
      2'd1:    sel_col = shadow_n[1];
      2'd2:    sel_col = shadow_n[2];
      default: sel_col = '0;
    endcase

    if (state_n == DRIVE) begin
      cols_n = (3'b001 << idx_n) ^ COLS_OFF;
      rows_n = sel_col ^ ROWS_OFF;
    end

    if (state_n != IDLE) begin
      cur_n = idx_n;
      fd_n  = (idx_n == 2'd2) && (p_n == P_LAST);
    end
  end

endmodule
